// File: rtl/sram_emu_if.sv
// Initiator-side control signals of the emulated asynchronous SRAM bus.
// The bidirectional data lines stay a plain inout port on the responder.
interface sram_emu_if;
    logic        sel;
    logic [20:0] SRAM_ADDR;
    logic        SRAM_WE_n;

    modport master (
        output sel,
        output SRAM_ADDR,
        output SRAM_WE_n
    );

    modport slave (
        input sel,
        input SRAM_ADDR,
        input SRAM_WE_n
    );
endinterface

// File: rtl/sram_emu.sv
// SRAM bus responder backed by an internal 2^AW x 8 memory.
// Fills the memory with FILL_VAL after reset, then serves reads and writes.
module sram_emu #(
    parameter int unsigned AW       = 16,
    parameter int unsigned RD_LAT   = 0,
    parameter logic [7:0]  FILL_VAL = 8'h00
) (
    input  logic        clka,
    input  logic        reset,
    sram_emu_if.slave   bus,
    inout  wire  [7:0]  SRAM_DATA,
    output logic        busy,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count,
    output logic        oor_err
);

    localparam int unsigned Depth = 1 << AW;

    typedef enum logic {StFill, StRun} state_e;

    state_e         state_q, state_d;
    logic [AW-1:0]  ptr_q, ptr_d;
    logic [15:0]    rd_count_q, rd_count_d;
    logic [15:0]    wr_count_q, wr_count_d;
    logic           oor_q, oor_d;
    logic [7:0]     mem_q [Depth];
    logic [7:0]     pipe_q [RD_LAT+1];

    logic           in_range;
    logic           acc, wr_acc, rd_acc;
    logic           mem_we;
    logic [AW-1:0]  mem_addr;
    logic [7:0]     mem_wdata;
    logic           drive_en;

    assign in_range = (bus.SRAM_ADDR >> AW) == 21'd0;
    assign acc      = (state_q == StRun) && bus.sel;
    assign wr_acc   = acc && !bus.SRAM_WE_n;
    assign rd_acc   = acc && bus.SRAM_WE_n;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        oor_d      = oor_q;
        mem_we     = 1'b0;
        mem_addr   = bus.SRAM_ADDR[AW-1:0];
        mem_wdata  = SRAM_DATA;
        unique case (state_q)
            StFill: begin
                mem_we    = 1'b1;
                mem_addr  = ptr_q;
                mem_wdata = FILL_VAL;
                ptr_d     = ptr_q + AW'(1);
                if (&ptr_q) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (wr_acc && in_range) begin
                    mem_we     = 1'b1;
                    wr_count_d = (wr_count_q == 16'hFFFF) ? wr_count_q : wr_count_q + 16'd1;
                end
                if (rd_acc) begin
                    rd_count_d = (rd_count_q == 16'hFFFF) ? rd_count_q : rd_count_q + 16'd1;
                end
                if (acc && !in_range) begin
                    oor_d = 1'b1;
                end
            end
        endcase
    end

    // Reset blocks the write so a reset cycle never commits bus data.
    always_ff @(posedge clka) begin
        if (mem_we && !reset) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    always_ff @(posedge clka) begin
        if (reset) begin
            state_q    <= StFill;
            ptr_q      <= '0;
            rd_count_q <= 16'd0;
            wr_count_q <= 16'd0;
            oor_q      <= 1'b0;
            for (int unsigned i = 0; i <= RD_LAT; i++) begin
                pipe_q[i] <= 8'h00;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
            oor_q      <= oor_d;
            if (rd_acc) begin
                pipe_q[0] <= in_range ? mem_q[bus.SRAM_ADDR[AW-1:0]] : 8'hFF;
            end
            for (int unsigned i = 1; i <= RD_LAT; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign busy     = (state_q == StFill);
    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
    assign oor_err  = oor_q;

    // Never drive while the initiator may be writing or the fill is running.
    assign drive_en  = bus.sel && bus.SRAM_WE_n && !busy;
    assign SRAM_DATA = drive_en ? pipe_q[RD_LAT] : 8'bz;

endmodule

// File: tb/tb_sram_emu.sv
// Scoreboard bench: two responders (RD_LAT 0 and 2) share one control bus,
// each with its own pulled-up data bus so high-Z reads back as 8'hFF.
module tb_sram_emu;

    logic clk;
    logic rst;

    sram_emu_if bus_if ();

    tri1 [7:0] d0;
    tri1 [7:0] d2;
    logic       tb_drv;
    logic [7:0] tb_wdata;

    assign d0 = tb_drv ? tb_wdata : 8'bz;
    assign d2 = tb_drv ? tb_wdata : 8'bz;

    logic        busy0, busy2, oor0, oor2;
    logic [15:0] rdc0, rdc2, wrc0, wrc2;

    sram_emu #(.AW(4), .RD_LAT(0), .FILL_VAL(8'hA5)) u_dut0 (
        .clka     (clk),
        .reset    (rst),
        .bus      (bus_if.slave),
        .SRAM_DATA(d0),
        .busy     (busy0),
        .rd_count (rdc0),
        .wr_count (wrc0),
        .oor_err  (oor0)
    );

    sram_emu #(.AW(4), .RD_LAT(2), .FILL_VAL(8'hA5)) u_dut2 (
        .clka     (clk),
        .reset    (rst),
        .bus      (bus_if.slave),
        .SRAM_DATA(d2),
        .busy     (busy2),
        .rd_count (rdc2),
        .wr_count (wrc2),
        .oor_err  (oor2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         due;
        logic [7:0] val;
    } sb_t;

    sb_t         q0[$];
    sb_t         q2[$];
    logic [7:0]  m [16];
    int          fill_left = 16;
    logic [15:0] rd_e = 16'd0;
    logic [15:0] wr_e = 16'd0;
    logic        oor_e = 1'b0;
    int          cyc = 0;
    int          n_vec = 0;
    int          n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic check_status(input string tag);
        check_eq({tag, " rd_count0"}, 32'(rdc0), 32'(rd_e));
        check_eq({tag, " rd_count2"}, 32'(rdc2), 32'(rd_e));
        check_eq({tag, " wr_count0"}, 32'(wrc0), 32'(wr_e));
        check_eq({tag, " wr_count2"}, 32'(wrc2), 32'(wr_e));
        check_eq({tag, " oor0"}, 32'(oor0), 32'(oor_e));
        check_eq({tag, " oor2"}, 32'(oor2), 32'(oor_e));
    endtask

    // Called just after a negedge; applies one bus cycle and checks at the next negedge.
    task automatic do_cycle(input logic r, input logic s, input logic we_n,
                            input logic [20:0] a, input logic [7:0] wd);
        logic       ir;
        logic       rd_mode;
        logic [7:0] v;
        sb_t        e;
        rst              = r;
        bus_if.sel       = s;
        bus_if.SRAM_WE_n = we_n;
        bus_if.SRAM_ADDR = a;
        tb_drv           = s && !we_n;
        tb_wdata         = wd;
        @(posedge clk);
        cyc++;
        if (r) begin
            fill_left = 16;
            rd_e      = 16'd0;
            wr_e      = 16'd0;
            oor_e     = 1'b0;
            for (int i = 0; i < 16; i++) m[i] = 8'hA5;
            q0.delete();
            q2.delete();
        end else if (fill_left > 0) begin
            fill_left--;
        end else if (s) begin
            ir = (a >> 4) == 21'd0;
            if (!ir) oor_e = 1'b1;
            if (!we_n) begin
                if (ir) begin
                    m[a[3:0]] = wd;
                    if (wr_e != 16'hFFFF) wr_e++;
                end
            end else begin
                v = ir ? m[a[3:0]] : 8'hFF;
                q0.push_back('{due: cyc, val: v});
                q2.push_back('{due: cyc + 2, val: v});
                if (rd_e != 16'hFFFF) rd_e++;
            end
        end
        @(negedge clk);
        rd_mode = s && we_n && (fill_left == 0);
        check_eq("busy0", 32'(busy0), 32'(fill_left != 0));
        check_eq("busy2", 32'(busy2), 32'(fill_left != 0));
        if (!rd_mode && !tb_drv) begin
            check_eq("hiz0", 32'(d0), 32'hFF);
            check_eq("hiz2", 32'(d2), 32'hFF);
        end
        while (q0.size() > 0 && q0[0].due <= cyc) begin
            e = q0.pop_front();
            if (rd_mode && e.due == cyc) check_eq("rdata0", 32'(d0), 32'(e.val));
        end
        while (q2.size() > 0 && q2[0].due <= cyc) begin
            e = q2.pop_front();
            if (rd_mode && e.due == cyc) check_eq("rdata2", 32'(d2), 32'(e.val));
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus_if.sel       = 1'b0;
        bus_if.SRAM_WE_n = 1'b1;
        bus_if.SRAM_ADDR = 21'd0;
        tb_drv           = 1'b0;
        tb_wdata         = 8'h00;
        @(negedge clk);

        // Reset with a competing write: reset must win.
        do_cycle(1'b1, 1'b1, 1'b0, 21'd5, 8'h42);
        do_cycle(1'b1, 1'b0, 1'b1, 21'd0, 8'h00);
        check_status("reset");

        // Fill: accesses ignored, busy exactly 16 cycles.
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 1'(i), 21'(i), 8'h99);
        check_status("fill");

        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 1'b1, 21'(i), 8'h00);
        check_status("readfill");

        // Write then read-after-write.
        do_cycle(1'b0, 1'b1, 1'b0, 21'h5, 8'h3C);
        do_cycle(1'b0, 1'b1, 1'b1, 21'h5, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b1, 21'h5, 8'h00);
        do_cycle(1'b0, 1'b0, 1'b1, 21'h0, 8'h00);
        check_status("raw");

        do_cycle(1'b0, 1'b1, 1'b0, 21'h1, 8'h11);
        do_cycle(1'b0, 1'b1, 1'b0, 21'h2, 8'h22);
        do_cycle(1'b0, 1'b1, 1'b0, 21'h3, 8'h33);
        for (int i = 1; i <= 5; i++) do_cycle(1'b0, 1'b1, 1'b1, 21'((i - 1) % 3 + 1), 8'h00);
        check_status("b2b");

        // Out-of-range: dropped write, 8'hFF read, sticky flag.
        do_cycle(1'b0, 1'b1, 1'b0, 21'h10, 8'h77);
        do_cycle(1'b0, 1'b1, 1'b1, 21'h0, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b1, 21'h10, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b0, 21'h100000, 8'h55);
        do_cycle(1'b0, 1'b1, 1'b1, 21'h100000, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b1, 21'h0, 8'h00);
        do_cycle(1'b0, 1'b1, 1'b1, 21'h0, 8'h00);
        check_status("oor");

        // Saturate the read counter.
        while (rd_e != 16'hFFFE) do_cycle(1'b0, 1'b1, 1'b1, 21'(cyc % 16), 8'h00);
        for (int i = 0; i < 3; i++) do_cycle(1'b0, 1'b1, 1'b1, 21'(i), 8'h00);
        check_status("sat");
        check_eq("rd_sat0", 32'(rdc0), 32'hFFFF);

        // Reset mid-RUN after a write.
        do_cycle(1'b0, 1'b1, 1'b0, 21'h7, 8'hAA);
        do_cycle(1'b1, 1'b1, 1'b1, 21'h7, 8'h00);
        check_status("rstrun");
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b0, 1'b1, 21'h0, 8'h00);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 1'b1, 21'(15 - i), 8'h00);
        check_status("refill");

        // Reset mid-FILL restarts the whole fill.
        do_cycle(1'b0, 1'b1, 1'b0, 21'h3, 8'h5A);
        do_cycle(1'b1, 1'b0, 1'b1, 21'h0, 8'h00);
        for (int i = 0; i < 5; i++) do_cycle(1'b0, 1'b1, 1'b0, 21'(i), 8'hC3);
        do_cycle(1'b1, 1'b0, 1'b1, 21'h0, 8'h00);
        for (int i = 0; i < 16; i++) do_cycle(1'b0, 1'b1, 1'b1, 21'(i), 8'h00);
        for (int i = 0; i < 6; i++) do_cycle(1'b0, 1'b1, 1'b1, 21'(i), 8'h00);
        check_status("rstfill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_emu.md
SRAM_EMU -- requirements
Module: sram_emu

Interface
REQ-001 Parameter AW, default 16: backing-store address width, 2^AW bytes.
REQ-002 Parameter RD_LAT, default 0, legal 0..3: extra read pipeline stages.
REQ-003 Parameter FILL_VAL, default 8'h00: value written to every location after reset.
REQ-004 clka  in  1: single clock; all state updates on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 sel  in  1: chip select, active high; the initiator's access enable.
REQ-007 SRAM_ADDR  in  21: byte address from the initiator.
REQ-008 SRAM_DATA  inout  8: bidirectional data bus.
REQ-009 SRAM_WE_n  in  1: write strobe, active low.
REQ-010 busy  out  1: high while the fill sequence runs.
REQ-011 rd_count  out  16: accepted read-cycle count, saturating.
REQ-012 wr_count  out  16: committed write count, saturating.
REQ-013 oor_err  out  1: sticky flag for an out-of-range access.

Function
REQ-014 The block SHALL be the responder for the SRAM bus, emulating the external SRAM with an internal 2^AW x 8 synchronous memory.
REQ-015 FSM states SHALL be FILL and RUN; reset enters FILL with fill pointer 0.
REQ-016 In FILL: one location written with FILL_VAL per cycle, pointer increments; after writing location 2^AW-1 -> RUN next cycle; busy=1 throughout FILL and 0 in RUN.
REQ-017 During FILL, bus accesses SHALL be ignored: no commit, no counting, SRAM_DATA high-Z.
REQ-018 In range: SRAM_ADDR[20:AW] all zero; otherwise the access is out of range.
REQ-019 Write: at a RUN edge with sel=1 and SRAM_WE_n=0 and in range, mem[SRAM_ADDR[AW-1:0]] <= SRAM_DATA; wr_count increments.
REQ-020 Read: at a RUN edge with sel=1 and SRAM_WE_n=1, mem at the address is registered into pipe stage 0 (8'hFF if out of range); rd_count increments.
REQ-021 Pipe SHALL advance one stage per cycle unconditionally; driven value = stage RD_LAT.
REQ-022 Read latency: data for an address presented before edge N SHALL be on SRAM_DATA after edge N+RD_LAT.
REQ-023 SRAM_DATA SHALL be driven only when sel=1, SRAM_WE_n=1 and busy=0; otherwise high-Z (never driven while the initiator writes).
REQ-024 Read of an address written at the immediately preceding edge SHALL return the new data.
REQ-025 Out-of-range write SHALL be dropped (memory unchanged, wr_count not incremented); any out-of-range access sets oor_err.
REQ-026 Counters SHALL hold at 16'hFFFF once reached.
REQ-027 With sel=0 nothing is committed or counted; pipe still advances.

Reset
REQ-028 reset=1 at an edge: state FILL, pointer 0, busy=1, rd_count=0, wr_count=0, oor_err=0, pipe stages 8'h00.
REQ-029 Reset asserted mid-FILL or mid-RUN SHALL restart the complete fill; prior memory contents are not preserved.
REQ-030 Reset dominates all bus activity in the same cycle.

Verification
REQ-031 AW=4, FILL_VAL=8'hA5: release reset -> busy high exactly 16 cycles; every read then returns 8'hA5.
REQ-032 RUN, RD_LAT=0: write 8'h3C to 0x0005, then read 0x0005 next cycle -> SRAM_DATA=8'h3C one edge later; wr_count=1, rd_count=1.
REQ-033 RD_LAT=2: read 0x0001..0x0003 back-to-back after writing 11/22/33 -> values appear in order, each 2 cycles later than with RD_LAT=0.
REQ-034 AW=4: write 8'h77 to 0x00010 -> memory unchanged, oor_err=1, wr_count unchanged; read of 0x00010 returns 8'hFF.
REQ-035 Preload rd_count=16'hFFFE via 3 reads -> count stops at 16'hFFFF; write attempts during busy=1 -> ignored, SRAM_DATA high-Z.
REQ-036 Assert reset mid-RUN after writes -> counters 0, busy high for full fill, prior data replaced by FILL_VAL.
